adc_capture_ctrl: RTL and testbench
===================================

# adc_capture_ctrl

Capture sequencer for the 8-bit ADC front end. It generates the ADC sample clock from the system clock and registers each converted sample. On command it waits for an optional rising-edge level trigger, then writes a fixed-length frame of samples into an external single-port capture RAM. It sits between the ADC pins and the frame consumer (FFT/UART readout) and hands each finished frame over with a ready/ack handshake.

## Interface
- DATA_W, 8, ADC sample width
- ADDR_W, 10, capture RAM address width; DEPTH = 2**ADDR_W
- DIV_W, 8, sample-period divisor width
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- cfg_div  in  DIV_W  sample period in clk cycles; values below 2 are treated as 2
- cfg_len  in  ADDR_W+1  frame length in samples; 0 or values above DEPTH are treated as DEPTH
- cfg_trig_en  in  1  1 = wait for trigger, 0 = capture immediately
- cfg_trig_level  in  DATA_W  unsigned trigger threshold
- start  in  1  one-cycle pulse; arms a capture
- abort  in  1  one-cycle pulse; cancels any capture
- rd_ack  in  1  consumer has read the frame
- AD0  in  DATA_W  ADC parallel data
- AD0_CLK  out  1  ADC sample clock
- buf_we  out  1  capture RAM write strobe
- buf_waddr  out  ADDR_W  capture RAM write address
- buf_wdata  out  DATA_W  capture RAM write data
- busy  out  1  high in ARM or CAPTURE
- done  out  1  one-cycle pulse when the last sample is written
- frame_ready  out  1  frame valid, held until rd_ack

## Operation
- Clock generator: the phase counter runs 0..div-1 continuously out of reset, and the divisor is reloaded from cfg_div only at phase wrap. AD0_CLK is a register that is high while phase < div>>1; the rising edge is at phase 0.
- Sample strobe: on the clk edge that ends phase div-1, AD0 is registered into smp and smp_vld pulses for one cycle; the previous sample is kept in smp_prev.
- States:
  - IDLE: on start, latch cfg_len, cfg_trig_en and cfg_trig_level, clear the address, and go to ARM.
  - ARM: with trig_en=0, go to CAPTURE on the first smp_vld and write that sample. With trig_en=1, trigger on smp_vld when smp_prev < level and smp >= level (both unsigned); the trigger sample is written at address 0. The first sample after arming only loads smp_prev and can never trigger.
  - CAPTURE: one write per smp_vld with address incrementing from 0. After the len-th write, pulse done and go to DONE.
  - DONE: hold frame_ready=1; on rd_ack, go to IDLE.
- start is ignored outside IDLE.
- abort in any state returns to IDLE on the next edge. It clears frame_ready, and no done pulse is issued. abort and start in the same cycle: abort wins.
- rd_ack outside DONE is ignored.
- Address never wraps within a frame; len=DEPTH ends at address DEPTH-1.

## Timing
- Reset values: AD0_CLK=0, phase=0, buf_we=0, buf_waddr=0, buf_wdata=0, busy=0, done=0, frame_ready=0, state=IDLE, smp/smp_prev=0.
- Sample-to-RAM latency: AD0 registered at the end of phase div-1; buf_we/buf_waddr/buf_wdata are registered and asserted during the next phase 0, for exactly one clk.
- done is asserted in the same cycle as the last buf_we; frame_ready rises on the following edge.
- busy rises the edge after start and falls the edge after the last write.
- Reset mid-capture: all outputs return to reset values immediately (asynchronous); the partial frame is abandoned.
- Minimum period of 2 gives 25 MSPS; write rate is at most one per two clks.

## Structure
- Package adc_cap_pkg: state enum (IDLE, ARM, CAPTURE, DONE), DIV_MIN=2, and the length/divisor clamp function.
- Sub-module adc_clk_gen: phase counter, divisor reload, AD0_CLK register, and sample strobe. The FSM, trigger compare and address counter stay in the top.

## Test plan
- Free-run clock: cfg_div=4 → AD0_CLK period 80 ns, high 40 ns; one smp_vld every 4 clks. cfg_div=0 and 1 → period 2 clks.
- Untriggered capture: div=4, len=16, AD0 = ramp 0,1,2,… → 16 writes at addresses 0..15 with consecutive data, done once, frame_ready held until rd_ack.
- Triggered capture: level=128, 50 kHz sine model (offset 128, amplitude 127) → first write at address 0 holds the first value ≥128 after a value <128. A falling crossing never triggers.
- Length clamp: len=0 and len=2000 → exactly 1024 writes, last at address 1023.
- Abort: abort after 5 writes in CAPTURE → no more buf_we, no done, busy low next cycle. start+abort together in IDLE → stays IDLE.
- Reset mid-frame: reset_n low in CAPTURE → all outputs at reset values asynchronously. A new start after release captures from address 0.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// Shared types and clamp helpers for the ADC capture sequencer.
package adc_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  localparam int unsigned DIV_MIN = 32'd2;

  function automatic int unsigned clamp_div(input int unsigned div);
    if (div < DIV_MIN) begin
      return DIV_MIN;
    end else begin
      return div;
    end
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    if ((len == 32'd0) || (len > depth)) begin
      return depth;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/adc_clk_gen.sv
// ADC sample clock generator: phase counter, divisor reload at wrap,
// registered AD0_CLK and the sample strobe/register.
module adc_clk_gen
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DATA_W-1:0] AD0,
  output logic              AD0_CLK,
  output logic              smp_stb,
  output logic [DATA_W-1:0] smp
);

  logic [DIV_W-1:0]  phase_r;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  phase_s;
  logic [DIV_W-1:0]  div_s;
  logic              wrap_s;
  logic              ad0_clk_r;
  logic [DATA_W-1:0] smp_r;

  // Next phase and divisor; the divisor only changes at the wrap
  always_comb begin
    wrap_s = (phase_r == (div_r - DIV_W'(1)));
    if (wrap_s) begin
      phase_s = '0;
      div_s   = DIV_W'(clamp_div(32'(cfg_div)));
    end else begin
      phase_s = phase_r + DIV_W'(1);
      div_s   = div_r;
    end
  end

  // Phase/divisor state, AD0_CLK register and sample capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_r   <= '0;
      div_r     <= DIV_W'(DIV_MIN);
      ad0_clk_r <= 1'b0;
      smp_r     <= '0;
    end else begin
      phase_r   <= phase_s;
      div_r     <= div_s;
      ad0_clk_r <= (phase_s < (div_s >> 1));
      if (wrap_s) begin
        smp_r <= AD0;
      end
    end
  end

  assign AD0_CLK = ad0_clk_r;
  assign smp_stb = wrap_s;
  assign smp     = smp_r;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: arms on start, optionally waits for a rising level
// crossing, writes one frame to the capture RAM and hands it off via rd_ack.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              cfg_trig_en,
  input  logic [DATA_W-1:0] cfg_trig_level,
  input  logic              start,
  input  logic              abort,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] AD0,
  output logic              AD0_CLK,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              busy,
  output logic              done,
  output logic              frame_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int          LEN_W = ADDR_W + 1;

  cap_state_e        state_r, state_s;
  logic [LEN_W-1:0]  len_r, len_s;
  logic [LEN_W-1:0]  addr_r, addr_s;
  logic              trig_en_r, trig_en_s;
  logic [DATA_W-1:0] level_r, level_s;
  logic              prev_ok_r, prev_ok_s;
  logic              smp_stb_s;
  logic [DATA_W-1:0] smp_s;
  logic              hit_s, wr_s, we_s, last_s;
  logic              buf_we_r, done_r, busy_r, frame_ready_r;
  logic [ADDR_W-1:0] buf_waddr_r;
  logic [DATA_W-1:0] buf_wdata_r;

  adc_clk_gen #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) u_clk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .cfg_div (cfg_div),
    .AD0     (AD0),
    .AD0_CLK (AD0_CLK),
    .smp_stb (smp_stb_s),
    .smp     (smp_s)
  );

  // Next-state, trigger compare and write decision. The strobe fires on the
  // edge that registers AD0, so the incoming AD0 is the new sample and smp_s
  // the previous one; this lands the write in the following phase 0.
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    addr_s    = addr_r;
    trig_en_s = trig_en_r;
    level_s   = level_r;
    prev_ok_s = prev_ok_r;
    wr_s      = 1'b0;
    we_s      = 1'b0;
    last_s    = 1'b0;
    hit_s     = prev_ok_r && (smp_s < level_r) && (AD0 >= level_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = ARM;
          len_s     = LEN_W'(clamp_len(32'(cfg_len), DEPTH));
          addr_s    = '0;
          trig_en_s = cfg_trig_en;
          level_s   = cfg_trig_level;
          prev_ok_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      ARM: begin
        if (smp_stb_s) begin
          if (!trig_en_r || hit_s) begin
            wr_s = 1'b1;
          end else begin
            prev_ok_s = 1'b1;
          end
        end else begin
          wr_s = 1'b0;
        end
      end
      CAPTURE: begin
        if (smp_stb_s) begin
          wr_s = 1'b1;
        end else begin
          wr_s = 1'b0;
        end
      end
      DONE: begin
        if (rd_ack) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (abort) begin
      state_s = IDLE;
      we_s    = 1'b0;
      last_s  = 1'b0;
    end else if (wr_s) begin
      we_s   = 1'b1;
      addr_s = addr_r + LEN_W'(1);
      if (addr_r == (len_r - LEN_W'(1))) begin
        last_s  = 1'b1;
        state_s = DONE;
      end else begin
        last_s  = 1'b0;
        state_s = CAPTURE;
      end
    end else begin
      we_s   = 1'b0;
      last_s = 1'b0;
    end
  end

  // FSM state, latched frame config and registered RAM/handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      len_r         <= '0;
      addr_r        <= '0;
      trig_en_r     <= 1'b0;
      level_r       <= '0;
      prev_ok_r     <= 1'b0;
      buf_we_r      <= 1'b0;
      buf_waddr_r   <= '0;
      buf_wdata_r   <= '0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      frame_ready_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      len_r         <= len_s;
      addr_r        <= addr_s;
      trig_en_r     <= trig_en_s;
      level_r       <= level_s;
      prev_ok_r     <= prev_ok_s;
      buf_we_r      <= we_s;
      if (we_s) begin
        buf_waddr_r <= addr_r[ADDR_W-1:0];
        buf_wdata_r <= AD0;
      end
      done_r        <= last_s;
      busy_r        <= (state_s == ARM) || (state_s == CAPTURE);
      frame_ready_r <= (state_r == DONE) && (state_s == DONE);
    end
  end

  assign buf_we      = buf_we_r;
  assign buf_waddr   = buf_waddr_r;
  assign buf_wdata   = buf_wdata_r;
  assign done        = done_r;
  assign busy        = busy_r;
  assign frame_ready = frame_ready_r;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: an ADC model drives AD0 on each
// AD0_CLK rise, expected RAM writes are queued at start and checked on buf_we.
module tb_adc_capture_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DIV_W  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DIV_W-1:0]  cfg_div = 8'd4;
  logic [ADDR_W:0]   cfg_len = 11'd16;
  logic              cfg_trig_en = 1'b0;
  logic [DATA_W-1:0] cfg_trig_level = 8'd128;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              rd_ack = 1'b0;
  logic [DATA_W-1:0] AD0 = 8'd0;
  logic              AD0_CLK;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [DATA_W-1:0] buf_wdata;
  logic              busy;
  logic              done;
  logic              frame_ready;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fails = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  drv_idx = 0;
  bit  sine_mode = 1'b0;

  adc_capture_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_div        (cfg_div),
    .cfg_len        (cfg_len),
    .cfg_trig_en    (cfg_trig_en),
    .cfg_trig_level (cfg_trig_level),
    .start          (start),
    .abort          (abort),
    .rd_ack         (rd_ack),
    .AD0            (AD0),
    .AD0_CLK        (AD0_CLK),
    .buf_we         (buf_we),
    .buf_waddr      (buf_waddr),
    .buf_wdata      (buf_wdata),
    .busy           (busy),
    .done           (done),
    .frame_ready    (frame_ready)
  );

  always #10 clk = ~clk;

  // ADC sample n: ramp, or 50 kHz sine at 12.5 MSPS (250 samples/period)
  function automatic logic [7:0] gen(input int idx);
    real r;
    if (sine_mode) begin
      r = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(idx) / 250.0);
      return 8'($rtoi(r + 0.5));
    end else begin
      return 8'(idx);
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // ADC model: new data follows each rising AD0_CLK
  always @(posedge AD0_CLK) begin
    drv_idx = drv_idx + 1;
    AD0 = gen(drv_idx);
  end

  // Write monitor / scoreboard
  always @(negedge clk) begin : mon
    wr_t e;
    if (reset_n && buf_we) begin
      wr_cnt++;
      check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("waddr", 32'(buf_waddr), 32'(e.addr));
        check("wdata", 32'(buf_wdata), 32'(e.data));
      end
    end
    if (reset_n && done) begin
      done_cnt++;
      check("done_with_last_write", 32'(buf_we && (exp_q.size() == 0)), 32'd1);
    end
  end

  task automatic measure_clk(output int hi, output int per);
    logic prev;
    int   n;
    hi = 0;
    per = 0;
    n = 0;
    do begin
      prev = AD0_CLK;
      @(negedge clk);
      n++;
    end while (!(AD0_CLK && !prev) && (n < 64));
    do begin
      per++;
      if (AD0_CLK) hi++;
      prev = AD0_CLK;
      @(negedge clk);
      n++;
    end while (!(AD0_CLK && !prev) && (n < 128));
  endtask

  task automatic start_capture(input int len_eff, input bit trig);
    int arm_idx;
    int j;
    @(posedge AD0_CLK);
    @(negedge clk);
    arm_idx = drv_idx;
    j = arm_idx;
    if (trig) begin
      j = arm_idx + 1;
      while (!((gen(j - 1) < cfg_trig_level) && (gen(j) >= cfg_trig_level)) && (j < arm_idx + 1000))
        j++;
    end
    for (int i = 0; i < len_eff; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: gen(j + i)});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int div, input int len_cfg, input int len_eff, input bit trig);
    int n;
    cfg_div = DIV_W'(div);
    cfg_len = 11'(len_cfg);
    cfg_trig_en = trig;
    wr_cnt = 0;
    done_cnt = 0;
    repeat (16) @(negedge clk);
    start_capture(len_eff, trig);
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    n = 0;
    while (!frame_ready && (n < len_eff * div * 2 + 2000)) begin
      @(negedge clk);
      n++;
    end
    check({tag, " frame_ready"}, 32'(frame_ready), 32'd1);
    check({tag, " writes"}, 32'(wr_cnt), 32'(len_eff));
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " busy_low"}, 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    check({tag, " frame_ready_held"}, 32'(frame_ready), 32'd1);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check({tag, " frame_ready_cleared"}, 32'(frame_ready), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int hi;
    int per;
    int n;
    #15;
    check("rst AD0_CLK", 32'(AD0_CLK), 32'd0);
    check("rst buf_we", 32'(buf_we), 32'd0);
    check("rst buf_waddr", 32'(buf_waddr), 32'd0);
    check("rst buf_wdata", 32'(buf_wdata), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst frame_ready", 32'(frame_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // free-running sample clock at several divisors
    cfg_div = 8'd4;
    repeat (16) @(negedge clk);
    measure_clk(hi, per);
    check("div4 period_ns", 32'(per * 20), 32'd80);
    check("div4 high_ns", 32'(hi * 20), 32'd40);
    cfg_div = 8'd0;
    repeat (16) @(negedge clk);
    measure_clk(hi, per);
    check("div0 period_clks", 32'(per), 32'd2);
    check("div0 high_clks", 32'(hi), 32'd1);
    cfg_div = 8'd1;
    repeat (16) @(negedge clk);
    measure_clk(hi, per);
    check("div1 period_clks", 32'(per), 32'd2);
    check("div1 high_clks", 32'(hi), 32'd1);

    // untriggered ramp frame
    run_frame("ramp", 4, 16, 16, 1'b0);

    // triggered sine frame, armed on the descending half so a falling crossing comes first
    sine_mode = 1'b1;
    cfg_trig_level = 8'd128;
    cfg_div = 8'd4;
    n = 0;
    while (((drv_idx % 250) != 80) && (n < 4000)) begin
      @(negedge clk);
      n++;
    end
    run_frame("trig", 4, 16, 16, 1'b1);
    sine_mode = 1'b0;

    // length clamp
    run_frame("len0", 2, 0, 1024, 1'b0);
    run_frame("len2000", 2, 2000, 1024, 1'b0);

    // abort after 5 writes
    cfg_div = 8'd4;
    cfg_len = 11'd16;
    cfg_trig_en = 1'b0;
    wr_cnt = 0;
    done_cnt = 0;
    repeat (16) @(negedge clk);
    start_capture(16, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((wr_cnt < 5) && (n < 200));
    check("abort reached_5_writes", 32'(wr_cnt), 32'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (40) @(negedge clk);
    check("abort writes", 32'(wr_cnt), 32'd5);
    check("abort done", 32'(done_cnt), 32'd0);
    check("abort frame_ready", 32'(frame_ready), 32'd0);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("start_abort writes", 32'(wr_cnt), 32'd5);

    // reset in the middle of a frame, while a write is on the bus
    wr_cnt = 0;
    done_cnt = 0;
    start_capture(16, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((wr_cnt < 3) && (n < 200));
    check("midrst write_on_bus", 32'(buf_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst buf_we", 32'(buf_we), 32'd0);
    check("midrst buf_waddr", 32'(buf_waddr), 32'd0);
    check("midrst buf_wdata", 32'(buf_wdata), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst AD0_CLK", 32'(AD0_CLK), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst frame_ready", 32'(frame_ready), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_frame("after_reset", 4, 16, 16, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
